// File: rtl/block_field_ctrl_pkg.sv
// Shared game constants, state encoding and the step-period helper
// for the falling-block sequencer.
package block_field_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_START = 2'b00,
    STATE_PLAY  = 2'b01,
    STATE_OVER  = 2'b10
  } game_state_t;

  localparam int ROW_W = 3;
  localparam int ROWS  = 8;
  localparam int COLS  = 4;
  localparam int COL_W = ROW_W * ROWS;

  localparam logic [ROW_W-1:0] BLACK = 3'b000;
  localparam logic [ROW_W-1:0] BLUE  = 3'b001;
  localparam logic [ROW_W-1:0] GREEN = 3'b010;
  localparam logic [ROW_W-1:0] RED   = 3'b100;
  localparam logic [ROW_W-1:0] WHITE = 3'b111;

  // The decrement is clamped before subtracting so the period never wraps.
  function automatic logic [31:0] step_period(input logic [7:0]  score,
                                              input logic [31:0] step_cycles,
                                              input logic [31:0] speedup,
                                              input logic [31:0] min_step);
    logic [31:0] dec;
    dec = 32'(score[7:4]) * speedup;
    if (step_cycles <= min_step || dec >= step_cycles - min_step) begin
      return min_step;
    end
    return step_cycles - dec;
  endfunction

endpackage

// File: rtl/block_field_ctrl_if.sv
// Player keys in, game state / score / field columns out.
interface block_field_ctrl_if;
  import block_field_ctrl_pkg::*;

  logic             key_start;
  logic [COLS-1:0]  key_hit;
  logic [1:0]       game_state;
  logic [7:0]       score;
  logic [COL_W-1:0] column_0;
  logic [COL_W-1:0] column_1;
  logic [COL_W-1:0] column_2;
  logic [COL_W-1:0] column_3;

  modport master (
    output key_start, key_hit,
    input  game_state, score, column_0, column_1, column_2, column_3
  );

  modport slave (
    input  key_start, key_hit,
    output game_state, score, column_0, column_1, column_2, column_3
  );

endinterface

// File: rtl/block_field_ctrl_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left; low OUT_W bits exposed.
module block_lfsr #(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         OUT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  always_ff @(posedge clk) begin
    if (srst) begin
      lfsr_reg <= SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[6:0], feedback};
    end
  end

  assign q = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/block_field_ctrl.sv
// Game sequencer: owns the 4x8 block field, game state and score, scrolls
// blocks on each step tick and resolves per-column hits.
module block_field_ctrl
  import block_field_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25_000_000,
  parameter int unsigned SPEEDUP     = 500_000,
  parameter int unsigned MIN_STEP    = 5_000_000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                CLK_50M,
  input  logic                RST,
  block_field_ctrl_if.slave   bus
);

  game_state_t      state_reg, state_next;
  logic [7:0]       score_reg, score_next;
  logic [31:0]      cnt_reg, cnt_next;
  logic [COL_W-1:0] field_reg  [COLS];
  logic [COL_W-1:0] field_next [COLS];

  logic [COL_W-1:0] cleared [COLS];
  logic [COL_W-1:0] shifted [COLS];
  logic [COLS-1:0]  row7_full, row7_left, hit_ok, hit_miss;
  logic [ROW_W-1:0] spawn_colour;
  logic [4:0]       lfsr_q;
  logic             lfsr_en;
  logic [31:0]      period;
  logic             step_tick;
  logic [8:0]       score_sum;

  block_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (5)
  ) u_lfsr (
    .clk  (CLK_50M),
    .srst (RST),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  assign period    = step_period(score_reg, 32'(STEP_CYCLES), 32'(SPEEDUP), 32'(MIN_STEP));
  assign step_tick = (state_reg == STATE_PLAY) && (cnt_reg >= period - 32'd1);

  assign spawn_colour = (lfsr_q[4:2] == BLACK) ? WHITE : lfsr_q[4:2];
  assign hit_ok       = bus.key_hit & row7_full;
  assign hit_miss     = bus.key_hit & ~row7_full;
  assign score_sum    = {1'b0, score_reg} + 9'($countones(hit_ok));

  // Hits are judged on the pre-step row 7; the shift then works on the cleared field.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign row7_full[gi] = |field_reg[gi][ROW_W-1:0];
    assign cleared[gi]   = hit_ok[gi] ? {field_reg[gi][COL_W-1:ROW_W], BLACK} : field_reg[gi];
    assign row7_left[gi] = |cleared[gi][ROW_W-1:0];
    assign shifted[gi]   = {(lfsr_q[1:0] == 2'(gi)) ? spawn_colour : BLACK,
                            cleared[gi][COL_W-1:ROW_W]};
  end

  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    cnt_next   = cnt_reg;
    lfsr_en    = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      field_next[c] = field_reg[c];
    end

    case (state_reg)
      STATE_START: begin
        if (bus.key_start) begin
          state_next = STATE_PLAY;
          score_next = 8'd0;
          cnt_next   = 32'd0;
          for (int c = 0; c < COLS; c++) begin
            field_next[c] = '0;
          end
        end
      end
      STATE_PLAY: begin
        cnt_next = step_tick ? 32'd0 : cnt_reg + 32'd1;
        if (|hit_ok) begin
          score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
        end
        for (int c = 0; c < COLS; c++) begin
          field_next[c] = cleared[c];
        end
        if (step_tick && !(|row7_left)) begin
          lfsr_en = 1'b1;
          for (int c = 0; c < COLS; c++) begin
            field_next[c] = shifted[c];
          end
        end
        if ((|hit_miss) || (step_tick && (|row7_left))) begin
          state_next = STATE_OVER;
        end
      end
      STATE_OVER: begin
        if (bus.key_start) begin
          state_next = STATE_START;
        end
      end
      default: state_next = STATE_START;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_reg <= STATE_START;
      score_reg <= 8'd0;
      cnt_reg   <= 32'd0;
      for (int c = 0; c < COLS; c++) begin
        field_reg[c] <= '0;
      end
    end else begin
      state_reg <= state_next;
      score_reg <= score_next;
      cnt_reg   <= cnt_next;
      for (int c = 0; c < COLS; c++) begin
        field_reg[c] <= field_next[c];
      end
    end
  end

  assign bus.game_state = state_reg;
  assign bus.score      = score_reg;
  assign bus.column_0   = field_reg[0];
  assign bus.column_1   = field_reg[1];
  assign bus.column_2   = field_reg[2];
  assign bus.column_3   = field_reg[3];

endmodule
